// File: rtl/restoring_divider8_pkg.sv
// Shared definitions for the 8-bit restoring divider: operand width,
// iteration count, FSM state encoding and the iteration counter type.
package restoring_divider8_pkg;

  localparam int DIV_WIDTH = 8;
  localparam int DIV_ITER  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef logic [3:0] count_t;

endpackage

// File: rtl/restoring_divider8_sub_borrow9.sv
// 9-bit ripple-borrow subtractor (a - b), built from a chain of full
// subtractors in the same style as the team's ripple-carry adder.
module sub_borrow9 (
  input  logic [8:0] a_i,
  input  logic [8:0] b_i,
  output logic [8:0] diff_o,
  output logic       borrow_o
);

  logic [9:0] bchain;

  assign bchain[0] = 1'b0;

  for (genvar i = 0; i < 9; i++) begin : g_fs
    logic axb;
    assign axb         = a_i[i] ^ b_i[i];
    assign diff_o[i]   = axb ^ bchain[i];
    assign bchain[i+1] = (~a_i[i] & b_i[i]) | (~axb & bchain[i]);
  end

  assign borrow_o = bchain[9];

endmodule

// File: rtl/restoring_divider8.sv
// Sequential 8-bit unsigned restoring divider, one quotient bit per clock,
// start/done handshake. Optional macro DIV_ZERO_TRAP_EN short-circuits a
// zero divisor straight to DONE and raises divByZero.
module restoring_divider8
  import restoring_divider8_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [DIV_WIDTH-1:0] dividend,
  input  logic [DIV_WIDTH-1:0] divisor,
  output logic [DIV_WIDTH-1:0] quotient,
  output logic [DIV_WIDTH-1:0] remainder,
  output logic                 busy,
  output logic                 done,
  output logic                 divByZero
);

  state_t               state_q;
  count_t               cnt_q;
  logic [DIV_WIDTH:0]   r_q;
  logic [DIV_WIDTH-1:0] q_q;
  logic [DIV_WIDTH-1:0] d_q;
  logic [DIV_WIDTH-1:0] quotient_q;
  logic [DIV_WIDTH-1:0] remainder_q;
  logic                 busy_q;
  logic                 done_q;

  logic [DIV_WIDTH:0]   s_d;
  logic [DIV_WIDTH:0]   t_d;
  logic                 borrow_d;
  logic [DIV_WIDTH:0]   r_d;
  logic [DIV_WIDTH-1:0] q_d;
  logic                 last_iter;

  // R never reaches D, so its top bit is always zero and only feeds the shift width.
  logic unused_r8;
  assign unused_r8 = r_q[DIV_WIDTH];

  assign s_d = {r_q[DIV_WIDTH-1:0], q_q[DIV_WIDTH-1]};

  sub_borrow9 u_sub (
    .a_i      (s_d),
    .b_i      ({1'b0, d_q}),
    .diff_o   (t_d),
    .borrow_o (borrow_d)
  );

  assign r_d       = borrow_d ? s_d : t_d;
  assign q_d       = {q_q[DIV_WIDTH-2:0], ~borrow_d};
  assign last_iter = (cnt_q == count_t'(DIV_ITER - 1));

`ifdef DIV_ZERO_TRAP_EN
  logic dbz_q;
  assign divByZero = dbz_q;
`else
  assign divByZero = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef DIV_ZERO_TRAP_EN
      dbz_q       <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            q_q     <= dividend;
            d_q     <= divisor;
            r_q     <= '0;
            cnt_q   <= '0;
            state_q <= RUN;
            busy_q  <= 1'b1;
`ifdef DIV_ZERO_TRAP_EN
            dbz_q   <= 1'b0;
            if (divisor == '0) begin
              state_q     <= DONE;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
              quotient_q  <= '1;
              remainder_q <= dividend;
              dbz_q       <= 1'b1;
            end
`endif
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          r_q   <= r_d;
          q_q   <= q_d;
          cnt_q <= cnt_q + count_t'(1);
          if (last_iter) begin
            state_q     <= DONE;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            quotient_q  <= q_d;
            remainder_q <= r_d[DIV_WIDTH-1:0];
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
